// File: rtl/axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regfile
//
// Generic AXI4-Lite slave register file. It holds DATA_DEPTH words of
// DATA_WIDTH bits, mapped from byte address BASE_ADDR upward. The read and
// write channels run independent FSMs, so a read and a write may be in
// flight at the same time.
//
// Ports:
//   ACLK, ARESETN          clock (rising edge); asynchronous active-low reset
//   S_AXI_AW*              write address channel (AWADDR, AWVALID, AWREADY)
//   S_AXI_W*               write data channel (WDATA, WSTRB, WVALID, WREADY)
//   S_AXI_B*               write response channel (BRESP, BVALID, BREADY)
//   S_AXI_AR*              read address channel (ARADDR, ARVALID, ARREADY)
//   S_AXI_R*               read data channel (RDATA, RRESP, RVALID, RREADY)
//   dbg_w_state_o          current write FSM state, for checkers
//   dbg_r_state_o          current read FSM state, for checkers
//
// Handshake rules: a transfer takes place on a rising ACLK edge where VALID
// and READY are both high. Every READY and VALID driven here comes straight
// from a flop. Once this slave raises BVALID or RVALID, it holds that signal
// and its payload unchanged until the matching READY is seen high.
// ---------------------------------------------------------------------------
module axi4_lite_slave_regfile #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter int unsigned              DATA_DEPTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [1:0]                S_AXI_BRESP,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   input  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY,
   output logic [1:0]                dbg_w_state_o,
   output logic                      dbg_r_state_o
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA} r_state_e;

   w_state_e                  w_state_q, w_state_d;
   r_state_e                  r_state_q, r_state_d;
   logic                      awready_q, wready_q, bvalid_q;
   logic                      arready_q, rvalid_q;
   logic [1:0]                bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0]     rdata_q;
   logic [ADDRESS_WIDTH-1:0]  awaddr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [STRB_W-1:0]         wstrb_q;
   logic [DATA_WIDTH-1:0]     mem_q [DATA_DEPTH];

   logic                      aw_hs, w_hs, ar_hs, commit;
   logic [ADDRESS_WIDTH-1:0]  wr_addr, wr_word, rd_word;
   logic [DATA_WIDTH-1:0]     wr_data;
   logic [STRB_W-1:0]         wr_strb;
   logic                      wr_hit, rd_hit;

   assign aw_hs = S_AXI_AWVALID & awready_q;
   assign w_hs  = S_AXI_WVALID  & wready_q;
   assign ar_hs = S_AXI_ARVALID & arready_q;

   // The final handshake may be on either channel. A handshake happening
   // this cycle takes its value from the bus; otherwise the latched copy is used.
   assign wr_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
   assign wr_data = w_hs  ? S_AXI_WDATA  : wdata_q;
   assign wr_strb = w_hs  ? S_AXI_WSTRB  : wstrb_q;

   // Word index = (addr - base) >> LSB. This drops the low alignment bits.
   // The subtraction wraps when addr < base, so that case is also rejected
   // explicitly.
   assign wr_word = (wr_addr - BASE_ADDR) >> LSB;
   assign rd_word = (S_AXI_ARADDR - BASE_ADDR) >> LSB;
   assign wr_hit  = (wr_addr >= BASE_ADDR) && (wr_word < ADDRESS_WIDTH'(DATA_DEPTH));
   assign rd_hit  = (S_AXI_ARADDR >= BASE_ADDR) && (rd_word < ADDRESS_WIDTH'(DATA_DEPTH));

   // ---------------- write FSM ----------------
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) w_state_d = W_RESP;
            else if (aw_hs)    w_state_d = W_WAIT_D;
            else if (w_hs)     w_state_d = W_WAIT_A;
         end
         W_WAIT_D: if (w_hs)         w_state_d = W_RESP;
         W_WAIT_A: if (aw_hs)        w_state_d = W_RESP;
         W_RESP:   if (S_AXI_BREADY) w_state_d = W_IDLE;
         default:                    w_state_d = W_IDLE;
      endcase
   end

   assign commit = (w_state_d == W_RESP) && (w_state_q != W_RESP);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         for (int i = 0; i < int'(DATA_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         w_state_q <= w_state_d;
         // The ready flags follow the next state. This keeps them registered
         // and holds them low for the first cycle after reset.
         awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_WAIT_A);
         wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_WAIT_D);
         bvalid_q  <= (w_state_d == W_RESP);
         if (aw_hs) awaddr_q <= S_AXI_AWADDR;
         if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
         end
         if (commit) begin
            bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit) begin
               for (int k = 0; k < int'(STRB_W); k++) begin
                  if (wr_strb[k]) mem_q[wr_word[IDX_W-1:0]][8*k +: 8] <= wr_data[8*k +: 8];
               end
            end
         end
      end
   end

   // ---------------- read FSM ----------------
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs)        r_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default:                   r_state_d = R_IDLE;
      endcase
   end

   // Reads sample mem_q before this edge's write lands, so a read and a write
   // to the same word on the same edge return the old contents.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= (r_state_d == R_IDLE);
         rvalid_q  <= (r_state_d == R_DATA);
         if (ar_hs) begin
            rdata_q <= rd_hit ? mem_q[rd_word[IDX_W-1:0]] : '0;
            rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign dbg_w_state_o = w_state_q;
   assign dbg_r_state_o = r_state_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave_regfile
//
// Directed bench for axi4_lite_slave_regfile with the default parameters
// (32-bit address and data, 32 words, base address 0). Inputs are driven 1 ns
// after each rising edge. Outputs are sampled at that same point, which is
// away from the active edge.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave_regfile;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] S_AXI_AWADDR;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [31:0] S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [1:0]  dbg_w_state;
   logic        dbg_r_state;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   axi4_lite_slave_regfile dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .dbg_w_state_o (dbg_w_state),
      .dbg_r_state_o (dbg_r_state)
   );

   // ---------------- clock / reset helpers ----------------
   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Present AW and W together and wait until both are accepted. BVALID must
   // be high right after the edge of the last handshake. The task finishes
   // with the B handshake.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      logic aw_hs, w_hs;
      int   n;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA  = data; S_AXI_WSTRB   = strb; S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b1;
      n = 0;
      while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
         tick();
         if (aw_hs) S_AXI_AWVALID = 1'b0;
         if (w_hs)  S_AXI_WVALID  = 1'b0;
         n++;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      chk("wr_hs_timeout", 32'(n >= 20), 32'd0);
      chk("bvalid_latency", 32'(S_AXI_BVALID), 32'd1);
      resp = S_AXI_BRESP;
      tick();
   endtask

   // Issue one read and wait until AR is accepted. RVALID must be high right
   // after the AR edge. The returned data is compared with the head of exp_q.
   task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp, input string tag);
      logic ar_hs;
      logic [31:0] exp_d;
      int n;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      n = 0;
      while (S_AXI_ARVALID && n < 20) begin
         ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
         tick();
         if (ar_hs) S_AXI_ARVALID = 1'b0;
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      chk("rd_hs_timeout", 32'(n >= 20), 32'd0);
      chk("rvalid_latency", 32'(S_AXI_RVALID), 32'd1);
      exp_d = exp_q.pop_front();
      chk(tag, S_AXI_RDATA, exp_d);
      chk("rresp", 32'(S_AXI_RRESP), 32'(exp_resp));
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [1:0] resp;
      ARESETN = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0;  S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

      // reset values
      tick(); tick();
      chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
      chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
      chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
      chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
      chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
      chk("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
      chk("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
      chk("rst_rdata",   S_AXI_RDATA,        32'd0);
      ARESETN = 1'b1;
      chk("rel_awready_low", 32'(S_AXI_AWREADY), 32'd0);
      tick();
      chk("rel_awready", 32'(S_AXI_AWREADY), 32'd1);
      chk("rel_wready",  32'(S_AXI_WREADY),  32'd1);
      chk("rel_arready", 32'(S_AXI_ARREADY), 32'd1);

      // AW and W presented together, then read the word back
      do_write(32'h08, 32'hDEADBEEF, 4'hF, resp);
      chk("bresp_basic", 32'(resp), 32'd0);
      exp_q.push_back(32'hDEADBEEF);
      do_read(32'h08, 2'b00, "rd_basic");

      // W three cycles before AW
      S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      chk("wfirst_wready0", 32'(S_AXI_WREADY), 32'd0);
      chk("wfirst_awready", 32'(S_AXI_AWREADY), 32'd1);
      tick();
      chk("wfirst_wready1", 32'(S_AXI_WREADY), 32'd0);
      tick();
      chk("wfirst_wready2", 32'(S_AXI_WREADY), 32'd0);
      chk("wfirst_nobvalid", 32'(S_AXI_BVALID), 32'd0);
      S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      chk("wfirst_bvalid", 32'(S_AXI_BVALID), 32'd1);
      chk("wfirst_wready3", 32'(S_AXI_WREADY), 32'd0);
      chk("wfirst_bresp", 32'(S_AXI_BRESP), 32'd0);
      tick();
      chk("wfirst_bdone", 32'(S_AXI_BVALID), 32'd0);
      exp_q.push_back(32'h11223344);
      do_read(32'h0C, 2'b00, "rd_wfirst");

      // clear mem[3], then the same write with AW first
      do_write(32'h0C, 32'h0, 4'hF, resp);
      S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      chk("awfirst_awready0", 32'(S_AXI_AWREADY), 32'd0);
      chk("awfirst_wready", 32'(S_AXI_WREADY), 32'd1);
      tick(); tick();
      chk("awfirst_awready1", 32'(S_AXI_AWREADY), 32'd0);
      S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      chk("awfirst_bvalid", 32'(S_AXI_BVALID), 32'd1);
      tick();
      exp_q.push_back(32'h11223344);
      do_read(32'h0C, 2'b00, "rd_awfirst");

      // partial strobes, then a write with no lanes enabled
      do_write(32'h08, 32'hAABBCCDD, 4'hF, resp);
      do_write(32'h08, 32'h00000000, 4'h5, resp);
      chk("bresp_strb5", 32'(resp), 32'd0);
      exp_q.push_back(32'hAA00CC00);
      do_read(32'h08, 2'b00, "rd_strb5");
      do_write(32'h0B, 32'hFFFFFFFF, 4'h0, resp);
      chk("bresp_strb0", 32'(resp), 32'd0);
      exp_q.push_back(32'hAA00CC00);
      do_read(32'h08, 2'b00, "rd_strb0");

      // address range edges: last word is valid, one past it is not
      do_write(32'h7C, 32'h12345678, 4'hF, resp);
      chk("bresp_last", 32'(resp), 32'd0);
      do_write(32'h80, 32'hFFFFFFFF, 4'hF, resp);
      chk("bresp_oor", 32'(resp), 32'd2);
      exp_q.push_back(32'h12345678);
      do_read(32'h7C, 2'b00, "rd_last_kept");
      exp_q.push_back(32'h00000000);
      do_read(32'h00, 2'b00, "rd_word0_kept");
      exp_q.push_back(32'h00000000);
      do_read(32'h1000, 2'b10, "rd_oor");

      // read and write of the same word on one edge, both responses stalled
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      S_AXI_AWADDR = 32'h7C; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h9ABCDEF0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 32'h7C; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid",  32'(S_AXI_BVALID),  32'd1);
         chk("bp_bresp",   32'(S_AXI_BRESP),   32'd0);
         chk("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
         chk("bp_rvalid",  32'(S_AXI_RVALID),  32'd1);
         chk("bp_rdata",   S_AXI_RDATA,        32'h12345678);
         chk("bp_rresp",   32'(S_AXI_RRESP),   32'd0);
         chk("bp_arready", 32'(S_AXI_ARREADY), 32'd0);
         tick();
      end
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      tick();
      chk("bp_bdone", 32'(S_AXI_BVALID), 32'd0);
      chk("bp_rdone", 32'(S_AXI_RVALID), 32'd0);
      exp_q.push_back(32'h9ABCDEF0);
      do_read(32'h7C, 2'b00, "rd_after_rbw");

      // reset while waiting for write data
      S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      chk("waitd_state", 32'(dbg_w_state), 32'd1);
      ARESETN = 1'b0;
      #1;
      chk("mid_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
      chk("mid_rst_wready",  32'(S_AXI_WREADY),  32'd0);
      chk("mid_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
      chk("mid_rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
      chk("mid_rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
      tick();
      ARESETN = 1'b1;
      tick();
      exp_q.push_back(32'h00000000);
      do_read(32'h08, 2'b00, "rd_cleared_08");
      exp_q.push_back(32'h00000000);
      do_read(32'h7C, 2'b00, "rd_cleared_7c");
      do_write(32'h14, 32'h0BADCAFE, 4'hF, resp);
      chk("bresp_post_rst", 32'(resp), 32'd0);
      exp_q.push_back(32'h0BADCAFE);
      do_read(32'h14, 2'b00, "rd_post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
